requant_argmax: RTL and testbench

Downstream stage of the MAC array: accepts one 20-bit signed accumulator per output neuron, adds a per-neuron bias, and rescales it with a rounding arithmetic right shift. It then applies optional ReLU and saturates the result to signed 8 bits for the next layer. A running argmax over each frame of N_OUT neurons produces the classification result for the final layer.

---
 rtl/requant_argmax.sv | 198 +++++++++++++++++++
 tb/tb_requant_argmax.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_argmax.sv
// Requantization stage behind the MAC array. Each beat gets its bias added, is
// rescaled with a rounding right shift, optionally ReLU'd, saturated to int8,
// and tracked by a per-frame argmax.
module requant_argmax #(
    parameter int N_OUT = 10,
    parameter int IDX_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_clr,
    input  logic [3:0]              shift,
    input  logic                    relu_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [19:0]      in_acc,
    input  logic signed [19:0]      in_bias,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [7:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    output logic                    pred_valid,
    output logic [IDX_W-1:0]        pred_idx,
    output logic signed [7:0]       pred_val
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    // Handshake / ready chain
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s2_load;
    logic s1_load;
    logic in_accept;
    logic out_xfer;

    assign s2_load   = !s2_valid_reg || out_ready;
    assign s1_load   = !s1_valid_reg || s2_load;
    assign in_ready  = s1_load && !frame_clr;
    assign in_accept = in_valid && in_ready;
    assign out_xfer  = s2_valid_reg && out_ready && !frame_clr;

    // Index counter
    logic [IDX_W-1:0] idx_cnt_reg;
    logic [IDX_W-1:0] idx_cnt_next;
    logic             idx_is_last;

    assign idx_is_last = (idx_cnt_reg == LAST_IDX);

    always_comb begin
        idx_cnt_next = idx_cnt_reg;
        if (frame_clr) begin
            idx_cnt_next = '0;
        end else if (in_accept) begin
            idx_cnt_next = idx_is_last ? '0 : idx_cnt_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_cnt_reg <= '0;
        end else begin
            idx_cnt_reg <= idx_cnt_next;
        end
    end

    // Stage 1: bias add plus half-LSB rounding offset; 22 bits cannot overflow
    logic signed [21:0] round_term;
    logic signed [21:0] s1_sum;
    logic signed [21:0] s1_r_reg;
    logic [IDX_W-1:0]   s1_idx_reg;
    logic               s1_last_reg;

    always_comb begin
        round_term = '0;
        if (shift != 4'd0) begin
            round_term = 22'sd1 <<< (shift - 4'd1);
        end
        s1_sum = {{2{in_acc[19]}}, in_acc} + {{2{in_bias[19]}}, in_bias} + round_term;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_r_reg     <= '0;
            s1_idx_reg   <= '0;
            s1_last_reg  <= 1'b0;
        end else if (frame_clr) begin
            s1_valid_reg <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg <= in_accept;
            if (in_accept) begin
                s1_r_reg    <= s1_sum;
                s1_idx_reg  <= idx_cnt_reg;
                s1_last_reg <= idx_is_last;
            end
        end
    end

    // Stage 2: arithmetic shift, optional ReLU, saturate to int8
    logic signed [21:0] q_shift;
    logic signed [7:0]  q_sat;
    logic signed [7:0]  out_data_reg;
    logic [IDX_W-1:0]   out_idx_reg;
    logic               out_last_reg;

    always_comb begin
        q_shift = s1_r_reg >>> shift;
        if (relu_en && (q_shift < 0)) begin
            q_shift = '0;
        end
        if (q_shift > 22'sd127) begin
            q_sat = 8'sd127;
        end else if (q_shift < -22'sd128) begin
            q_sat = -8'sd128;
        end else begin
            q_sat = q_shift[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            out_data_reg <= '0;
            out_idx_reg  <= '0;
            out_last_reg <= 1'b0;
        end else if (frame_clr) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_data_reg <= q_sat;
                out_idx_reg  <= s1_idx_reg;
                out_last_reg <= s1_last_reg;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;
    assign out_last  = out_last_reg;

    // Running argmax; strict compare keeps the lowest index on ties
    logic signed [7:0]  max_val_reg;
    logic [IDX_W-1:0]   max_idx_reg;
    logic signed [7:0]  max_val_next;
    logic [IDX_W-1:0]   max_idx_next;
    logic               take_beat;

    assign take_beat = (out_idx_reg == '0) || (out_data_reg > max_val_reg);

    always_comb begin
        max_val_next = max_val_reg;
        max_idx_next = max_idx_reg;
        if (out_xfer && take_beat) begin
            max_val_next = out_data_reg;
            max_idx_next = out_idx_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val_reg <= '0;
            max_idx_reg <= '0;
        end else if (frame_clr) begin
            max_val_reg <= '0;
            max_idx_reg <= '0;
        end else begin
            max_val_reg <= max_val_next;
            max_idx_reg <= max_idx_next;
        end
    end

    // Prediction pulse follows the transfer of the frame's last beat
    logic               pred_valid_reg;
    logic [IDX_W-1:0]   pred_idx_reg;
    logic signed [7:0]  pred_val_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_reg <= 1'b0;
            pred_idx_reg   <= '0;
            pred_val_reg   <= '0;
        end else begin
            pred_valid_reg <= out_xfer && out_last_reg;
            if (out_xfer && out_last_reg) begin
                pred_idx_reg <= max_idx_next;
                pred_val_reg <= max_val_next;
            end
        end
    end

    assign pred_valid = pred_valid_reg;
    assign pred_idx   = pred_idx_reg;
    assign pred_val   = pred_val_reg;

endmodule

// File: tb/tb_requant_argmax.sv
// Directed bench for requant_argmax with a real-arithmetic reference model
// checked every cycle, plus literal expectations from hand calculation.
module tb_requant_argmax;

    localparam int N_OUT = 10;
    localparam int IDX_W = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   frame_clr = 1'b0;
    logic [3:0]             shift = 4'd7;
    logic                   relu_en = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic signed [19:0]     in_acc = '0;
    logic signed [19:0]     in_bias = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic signed [7:0]      out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic                   pred_valid;
    logic [IDX_W-1:0]       pred_idx;
    logic signed [7:0]      pred_val;

    requant_argmax #(.N_OUT(N_OUT), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .frame_clr(frame_clr), .shift(shift),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
        .in_acc(in_acc), .in_bias(in_bias), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .pred_valid(pred_valid), .pred_idx(pred_idx),
        .pred_val(pred_val)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact real-valued rescale, round half up, ReLU, clamp
    function automatic int model_q(input int acc, input int bias, input int sh, input bit relu);
        real x;
        int  q;
        x = real'(acc + bias) / (2.0 ** sh);
        q = int'($floor(x + 0.5));
        if (relu && q < 0) q = 0;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    typedef struct { int data; int idx; bit last; int age; } beat_t;
    typedef struct { int acc; int bias; } stim_t;

    beat_t mq[$];
    stim_t sq[$];
    int    m_idx = 0;
    int    m_max = 0;
    int    m_maxi = 0;
    bit    m_pend = 0;
    int    m_pidx = 0;
    int    m_pval = 0;
    bit    took = 0;
    int    pred_seen = 0;
    int    acc_cnt = 0;

    // Per-cycle comparison against the model, then model advance for the next edge
    always @(negedge clk) begin
        bit    exp_ready;
        bit    exp_valid;
        beat_t h;
        if (rst) begin
            mq.delete();
            m_idx = 0;
            m_pend = 0;
            took = 0;
        end else begin
            exp_ready = !frame_clr && (mq.size() < 2 || out_ready);
            exp_valid = (mq.size() > 0) && (mq[0].age >= 1);
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("out_data", 32'(out_data), mq[0].data);
                chk("out_idx", 32'(out_idx), mq[0].idx);
                chk("out_last", 32'(out_last), 32'(mq[0].last));
            end
            chk("pred_valid", 32'(pred_valid), 32'(m_pend));
            if (m_pend) begin
                chk("pred_idx", 32'(pred_idx), m_pidx);
                chk("pred_val", 32'(pred_val), m_pval);
            end
            if (pred_valid) pred_seen++;
            m_pend = 0;
            if (frame_clr) begin
                mq.delete();
                m_idx = 0;
                took = 0;
            end else begin
                if (exp_valid && out_ready) begin
                    h = mq.pop_front();
                    if (h.idx == 0 || h.data > m_max) begin
                        m_max = h.data;
                        m_maxi = h.idx;
                    end
                    if (h.last) begin
                        m_pend = 1;
                        m_pidx = m_maxi;
                        m_pval = m_max;
                    end
                end
                foreach (mq[i]) mq[i].age = 1;
                took = in_valid && exp_ready;
                if (took) begin
                    h.data = model_q(int'(in_acc), int'(in_bias), int'(shift), relu_en);
                    h.idx  = m_idx;
                    h.last = (m_idx == N_OUT - 1);
                    h.age  = 0;
                    mq.push_back(h);
                    m_idx = (m_idx == N_OUT - 1) ? 0 : m_idx + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (took && sq.size() > 0) begin
            void'(sq.pop_front());
            acc_cnt++;
        end
        if (sq.size() > 0) begin
            in_valid = 1'b1;
            in_acc   = 20'(sq[0].acc);
            in_bias  = 20'(sq[0].bias);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic push(input int acc, input int bias);
        stim_t s;
        s.acc = acc;
        s.bias = bias;
        sq.push_back(s);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        step();
        while ((sq.size() > 0 || mq.size() > 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_done", 32'(n < 300), 32'sd1);
        step();
        step();
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'sd1);
    endtask

    task automatic pulse_clr();
        frame_clr = 1'b1;
        step();
        frame_clr = 1'b0;
    endtask

    int base;
    int frame_vals[10] = '{3, -5, 0, 9, 2, 1, 20, 7, 20, -128};

    initial begin
        #1 rst = 1'b1;
        #10;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_pred_valid", 32'(pred_valid), 0);
        #12 rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 1);

        // Model pins from hand arithmetic
        chk("pin_1000_s7", model_q(1000, 0, 7, 0), 8);
        chk("pin_m192_s7", model_q(-192, 0, 7, 0), -1);
        chk("pin_m64_s7", model_q(-64, 0, 7, 0), 0);
        chk("pin_5m3_s0", model_q(5, -3, 0, 0), 2);
        chk("pin_sat_hi", model_q(100000, 0, 4, 0), 127);
        chk("pin_sat_lo", model_q(-100000, 0, 4, 0), -128);
        chk("pin_relu", model_q(-100000, 0, 4, 1), 0);
        chk("pin_bias_carry", model_q(524287, 524287, 15, 0), 32);

        // Rounding
        shift = 4'd7; relu_en = 1'b0; out_ready = 1'b1;
        push(1000, 0); push(-192, 0); push(-64, 0);
        wait_out_valid();
        chk("first_out_data", 32'(out_data), 8);
        chk("first_out_idx", 32'(out_idx), 0);
        wait_drain();
        shift = 4'd0;
        push(5, -3);
        wait_drain();

        // Saturation, ReLU, bias carry
        shift = 4'd4;
        push(100000, 0); push(-100000, 0);
        wait_drain();
        relu_en = 1'b1;
        push(100000, 0); push(-100000, 0);
        wait_drain();
        relu_en = 1'b0; shift = 4'd15;
        push(524287, 524287);
        wait_drain();

        // Back-pressure: two beats buffered, output held
        shift = 4'd7; out_ready = 1'b0; acc_cnt = 0;
        push(128, 0); push(256, 0); push(384, 0); push(512, 0);
        repeat (6) step();
        chk("bp_accepted", acc_cnt, 2);
        chk("bp_hold_data", 32'(out_data), 1);
        out_ready = 1'b1;
        wait_drain();

        // Argmax frame with ties
        pulse_clr();
        shift = 4'd0;
        base = pred_seen;
        foreach (frame_vals[i]) push(frame_vals[i], 0);
        wait_drain();
        chk("frame_pred_count", pred_seen - base, 1);
        chk("frame_pred_idx", 32'(pred_idx), 6);
        chk("frame_pred_val", 32'(pred_val), 20);

        // Mid-frame flush
        pulse_clr();
        base = pred_seen;
        push(1, 0); push(2, 0); push(3, 0); push(4, 0);
        while (sq.size() > 0) step();
        in_valid = 1'b1; in_acc = 20'sd77; frame_clr = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        frame_clr = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 0);
        push(9, 0);
        wait_out_valid();
        chk("flush_next_idx", 32'(out_idx), 0);
        wait_drain();
        chk("flush_no_pred", pred_seen - base, 0);

        // Asynchronous reset mid-cycle
        out_ready = 1'b0;
        push(5, 0); push(6, 0);
        repeat (4) step();
        chk("pre_rst_out_valid", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_out_idx", 32'(out_idx), 0);
        chk("arst_out_last", 32'(out_last), 0);
        chk("arst_pred_valid", 32'(pred_valid), 0);
        chk("arst_pred_idx", 32'(pred_idx), 0);
        chk("arst_pred_val", 32'(pred_val), 0);
        in_valid = 1'b0;
        sq.delete();
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("arst_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        push(3, 0);
        step();
        wait_out_valid();
        chk("arst_next_idx", 32'(out_idx), 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
